// File: rtl/eth_frame_serializer_if.sv
// Handshake bundle between the frame source, eth_frame_serializer and the Manchester encoder.
interface eth_frame_serializer_if;
    logic        start;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        pl_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;

    modport master (
        output start, dst_mac, src_mac, eth_type, pl_data, pl_valid, pl_last, bit_ready,
        input  pl_ready, bit_out, bit_valid, busy, frame_done, frame_abort
    );

    modport slave (
        input  start, dst_mac, src_mac, eth_type, pl_data, pl_valid, pl_last, bit_ready,
        output pl_ready, bit_out, bit_valid, busy, frame_done, frame_abort
    );
endinterface

// File: rtl/eth_frame_serializer.sv
// 10BASE-T frame serializer: preamble/SFD/header/payload/FCS streamed LSB-first, then inter-frame gap.
// Define ETH_SER_PAD_EN to zero-pad short payloads up to MIN_PAYLOAD bytes.
module eth_frame_serializer #(
    parameter int unsigned IFG_BITS    = 96,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500
) (
    input  logic                   CLK,
    input  logic                   RST,
    eth_frame_serializer_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_HDR  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
`ifdef ETH_SER_PAD_EN
    localparam logic [2:0] S_PAD  = 3'd5;
`endif
    localparam logic [2:0] S_FCS  = 3'd6;
    localparam logic [2:0] S_IFG  = 3'd7;

    localparam int unsigned CNT_MAX  = (MAX_PAYLOAD > MIN_PAYLOAD) ? MAX_PAYLOAD : MIN_PAYLOAD;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned IFG_W    = $clog2(IFG_BITS + 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    logic [2:0]       state;
    logic [7:0]       sh;
    logic [2:0]       idx;
    logic [3:0]       byte_cnt;
    logic [111:0]     hdr;
    logic [CNT_W-1:0] pay_cnt;
    logic             last_q;
    logic [31:0]      crc;
    logic [IFG_W-1:0] ifg_cnt;
    logic             bit_valid_q;
    logic             done_q;
    logic             abort_q;

    logic             hs;
    logic             byte_end;
    logic             need_byte;
    logic             crc_en;
    logic [31:0]      crc_nxt;

    assign hs       = bit_valid_q && bus.bit_ready;
    assign byte_end = hs && (idx == 3'd7);
    // A payload byte is pulled on the edge that retires the previous byte's last bit.
    assign need_byte = byte_end &&
                       (((state == S_HDR) && (byte_cnt == 4'd13)) ||
                        ((state == S_PAY) && !last_q && (pay_cnt != CNT_W'(MAX_PAYLOAD))));
`ifdef ETH_SER_PAD_EN
    assign crc_en = hs && ((state == S_HDR) || (state == S_PAY) || (state == S_PAD));
`else
    assign crc_en = hs && ((state == S_HDR) || (state == S_PAY));
`endif

    always_comb begin
        crc_nxt = {1'b0, crc[31:1]};
        if (crc[0] ^ sh[0]) begin
            crc_nxt = crc_nxt ^ CRC_POLY;
        end
    end

    assign bus.pl_ready    = need_byte;
    assign bus.bit_out     = (state == S_FCS) ? ~crc[0] : sh[0];
    assign bus.bit_valid   = bit_valid_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            sh          <= '0;
            idx         <= '0;
            byte_cnt    <= '0;
            hdr         <= '0;
            pay_cnt     <= '0;
            last_q      <= 1'b0;
            crc         <= '1;
            ifg_cnt     <= '0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (crc_en) begin
                crc <= crc_nxt;
            end
            if (hs) begin
                idx <= idx + 3'd1;
                sh  <= {1'b0, sh[7:1]};
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        hdr         <= {bus.dst_mac, bus.src_mac, bus.eth_type};
                        sh          <= 8'h55;
                        idx         <= '0;
                        byte_cnt    <= '0;
                        pay_cnt     <= '0;
                        last_q      <= 1'b0;
                        crc         <= '1;
                        bit_valid_q <= 1'b1;
                        state       <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (byte_end) begin
                        if (byte_cnt == 4'd6) begin
                            sh       <= 8'hD5;
                            byte_cnt <= '0;
                            state    <= S_SFD;
                        end else begin
                            sh       <= 8'h55;
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                S_SFD: begin
                    if (byte_end) begin
                        sh    <= hdr[111:104];
                        hdr   <= {hdr[103:0], 8'h00};
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (byte_end) begin
                        if (byte_cnt == 4'd13) begin
                            if (bus.pl_valid) begin
                                sh      <= bus.pl_data;
                                pay_cnt <= CNT_W'(1);
                                last_q  <= bus.pl_last;
                                state   <= S_PAY;
                            end else begin
                                abort_q     <= 1'b1;
                                bit_valid_q <= 1'b0;
                                ifg_cnt     <= '0;
                                state       <= S_IFG;
                            end
                        end else begin
                            sh       <= hdr[111:104];
                            hdr      <= {hdr[103:0], 8'h00};
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (byte_end) begin
                        if (last_q) begin
`ifdef ETH_SER_PAD_EN
                            if (pay_cnt < CNT_W'(MIN_PAYLOAD)) begin
                                sh      <= '0;
                                pay_cnt <= pay_cnt + CNT_W'(1);
                                state   <= S_PAD;
                            end else begin
                                byte_cnt <= '0;
                                state    <= S_FCS;
                            end
`else
                            byte_cnt <= '0;
                            state    <= S_FCS;
`endif
                        end else if (pay_cnt == CNT_W'(MAX_PAYLOAD) || !bus.pl_valid) begin
                            abort_q     <= 1'b1;
                            bit_valid_q <= 1'b0;
                            ifg_cnt     <= '0;
                            state       <= S_IFG;
                        end else begin
                            sh      <= bus.pl_data;
                            pay_cnt <= pay_cnt + CNT_W'(1);
                            last_q  <= bus.pl_last;
                        end
                    end
                end
`ifdef ETH_SER_PAD_EN
                S_PAD: begin
                    if (byte_end) begin
                        sh <= '0;
                        if (pay_cnt == CNT_W'(MIN_PAYLOAD)) begin
                            byte_cnt <= '0;
                            state    <= S_FCS;
                        end else begin
                            pay_cnt <= pay_cnt + CNT_W'(1);
                        end
                    end
                end
`endif
                S_FCS: begin
                    // The finished CRC register is shifted out directly; bit_out presents its complement.
                    if (hs) begin
                        crc <= {1'b0, crc[31:1]};
                    end
                    if (byte_end) begin
                        if (byte_cnt == 4'd3) begin
                            done_q      <= 1'b1;
                            bit_valid_q <= 1'b0;
                            ifg_cnt     <= '0;
                            state       <= S_IFG;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                S_IFG: begin
                    if (bus.bit_ready) begin
                        if (ifg_cnt == IFG_W'(IFG_BITS - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + IFG_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_frame_serializer.sv
// Directed frame vectors for eth_frame_serializer: bit stream, CRC residue, pulses, IFG length, reset.
module tb_eth_frame_serializer;
    localparam int unsigned IFG_BITS    = 96;
    localparam int unsigned MAX_PAYLOAD = 1500;
    localparam int          BUDGET      = 20000;

    logic CLK = 1'b0;
    logic RST;

    eth_frame_serializer_if bus();

    eth_frame_serializer #(
        .IFG_BITS    (IFG_BITS),
        .MIN_PAYLOAD (46),
        .MAX_PAYLOAD (MAX_PAYLOAD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int len;
        int underrun_at;
        bit last_en;
        bit toggle;
        bit spam;
        int seed;
        int exp_bits;
        int exp_done;
        int exp_abort;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rx_q[$];
    logic [7:0]  exp_bytes[$];
    logic [47:0] dst_v  = 48'hFF_FF_FF_FF_FF_FF;
    logic [47:0] src_v  = 48'h02_00_00_00_00_01;
    logic [15:0] type_v = 16'h0800;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input bit b);
        logic [31:0] r;
        r = c >> 1;
        if (c[0] ^ b) r = r ^ 32'hEDB88320;
        return r;
    endfunction

    function automatic logic [7:0] pay_byte(input int seed, input int i);
        if (seed == 0) return 8'h00;
        return 8'((i * 37 + seed) & 255);
    endfunction

    task automatic build_expected(input vec_t v);
        int          nsent;
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        exp_bytes.delete();
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_bytes.push_back(dst_v[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_bytes.push_back(src_v[47 - 8*i -: 8]);
        exp_bytes.push_back(type_v[15:8]);
        exp_bytes.push_back(type_v[7:0]);
        nsent = (v.underrun_at >= 0) ? v.underrun_at : v.len;
        for (int i = 0; i < nsent; i++) exp_bytes.push_back(pay_byte(v.seed, i));
        if (v.exp_done != 0) begin
`ifdef ETH_SER_PAD_EN
            while (exp_bytes.size() < 22 + 46) exp_bytes.push_back(8'h00);
`endif
            c = '1;
            for (int i = 8; i < exp_bytes.size(); i++) begin
                b = exp_bytes[i];
                for (int k = 0; k < 8; k++) c = crc_bit(c, b[k]);
            end
            fcs = ~c;
            for (int i = 0; i < 4; i++) exp_bytes.push_back(fcs[8*i +: 8]);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int nxt = 0;
        int cyc = 0;
        int ndone = 0;
        int nabort = 0;
        int nifg = 0;
        int quiet = 0;
        int mism = 0;
        int ones = 0;
        int lim;
        logic [7:0]  b;
        logic [31:0] res;

        rx_q.delete();
        build_expected(v);
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.bit_ready = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        #1;
        chk({tag, "_pre_valid"}, 64'(bus.bit_valid), 64'd1);
        chk({tag, "_pre_bit"},   64'(bus.bit_out),   64'd1);
        chk({tag, "_pre_busy"},  64'(bus.busy),      64'd1);

        while (cyc < BUDGET) begin
            bus.start     = 1'b0;
            bus.bit_ready = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.pl_valid  = (nxt < v.len) && (nxt != v.underrun_at);
            bus.pl_data   = pay_byte(v.seed, nxt);
            bus.pl_last   = v.last_en && (nxt == v.len - 1);
            #1;
            if (!bus.busy) break;
            if (bus.frame_done)  ndone++;
            if (bus.frame_abort) nabort++;
            if (bus.bit_valid && bus.bit_ready) rx_q.push_back(bus.bit_out);
            if (bus.pl_ready && bus.pl_valid) nxt++;
            if (!bus.bit_valid && bus.bit_ready) nifg++;
            // Extra starts while busy, including the cycle IFG completes, must be ignored.
            if (v.spam && (((cyc % 7) == 3) || (nifg == IFG_BITS))) bus.start = 1'b1;
            @(negedge CLK);
            cyc++;
        end
        bus.start     = 1'b0;
        bus.bit_ready = 1'b1;
        bus.pl_valid  = 1'b0;
        chk({tag, "_timeout"}, 64'(cyc >= BUDGET), 64'd0);

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            if (bus.busy) quiet++;
        end

        chk({tag, "_nbits"}, 64'(rx_q.size()), 64'(v.exp_bits));
        chk({tag, "_done"},  64'(ndone),       64'(v.exp_done));
        chk({tag, "_abort"}, 64'(nabort),      64'(v.exp_abort));
        chk({tag, "_ifg"},   64'(nifg),        64'(IFG_BITS));
        chk({tag, "_idle"},  64'(quiet),       64'd0);

        lim = (rx_q.size() < exp_bytes.size() * 8) ? rx_q.size() : exp_bytes.size() * 8;
        for (int i = 0; i < lim; i++) begin
            b = exp_bytes[i / 8];
            if (rx_q[i] != b[i % 8]) mism++;
        end
        chk({tag, "_bits"}, 64'(mism), 64'd0);

        if (v.seed == 0 && rx_q.size() >= 112) begin
            for (int i = 64; i < 112; i++) if (rx_q[i]) ones++;
            chk({tag, "_dst_ones"}, 64'(ones), 64'd48);
        end

        if (v.exp_done != 0) begin
            res = '1;
            for (int i = 64; i < rx_q.size(); i++) res = crc_bit(res, rx_q[i]);
            chk({tag, "_residue"}, 64'(res), 64'hDEBB20E3);
        end
    endtask

    initial begin
        vec_t vecs[7];

        vecs[0] = '{len:46,   underrun_at:-1, last_en:1, toggle:0, spam:0, seed:0,
                    exp_bits:576, exp_done:1, exp_abort:0};
`ifdef ETH_SER_PAD_EN
        vecs[1] = '{len:10,   underrun_at:-1, last_en:1, toggle:0, spam:0, seed:5,
                    exp_bits:576, exp_done:1, exp_abort:0};
        vecs[4] = '{len:1,    underrun_at:-1, last_en:1, toggle:0, spam:0, seed:9,
                    exp_bits:576, exp_done:1, exp_abort:0};
`else
        vecs[1] = '{len:10,   underrun_at:-1, last_en:1, toggle:0, spam:0, seed:5,
                    exp_bits:288, exp_done:1, exp_abort:0};
        vecs[4] = '{len:1,    underrun_at:-1, last_en:1, toggle:0, spam:0, seed:9,
                    exp_bits:216, exp_done:1, exp_abort:0};
`endif
        vecs[2] = '{len:10,   underrun_at:4,  last_en:1, toggle:0, spam:0, seed:3,
                    exp_bits:208, exp_done:0, exp_abort:1};
        vecs[3] = '{len:60,   underrun_at:-1, last_en:1, toggle:1, spam:1, seed:17,
                    exp_bits:688, exp_done:1, exp_abort:0};
        vecs[5] = '{len:46,   underrun_at:-1, last_en:1, toggle:1, spam:1, seed:0,
                    exp_bits:576, exp_done:1, exp_abort:0};
        vecs[6] = '{len:1500, underrun_at:-1, last_en:0, toggle:0, spam:0, seed:11,
                    exp_bits:12176, exp_done:0, exp_abort:1};

        bus.start     = 1'b0;
        bus.dst_mac   = dst_v;
        bus.src_mac   = src_v;
        bus.eth_type  = type_v;
        bus.pl_data   = 8'h00;
        bus.pl_valid  = 1'b0;
        bus.pl_last   = 1'b0;
        bus.bit_ready = 1'b1;
        RST = 1'b1;
        #12;
        chk("rst_pl_ready",    64'(bus.pl_ready),    64'd0);
        chk("rst_bit_out",     64'(bus.bit_out),     64'd0);
        chk("rst_bit_valid",   64'(bus.bit_valid),   64'd0);
        chk("rst_busy",        64'(bus.busy),        64'd0);
        chk("rst_frame_done",  64'(bus.frame_done),  64'd0);
        chk("rst_frame_abort", 64'(bus.frame_abort), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Reset while the header is being shifted out.
        @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (100) @(negedge CLK);
        #1;
        chk("midhdr_valid", 64'(bus.bit_valid), 64'd1);
        RST = 1'b1;
        #1;
        chk("midhdr_rst_valid", 64'(bus.bit_valid), 64'd0);
        chk("midhdr_rst_busy",  64'(bus.busy),      64'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
